// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-stage program counter: default widths,
// reset/exception vectors, redirect priorities and the PC FSM states.
package mips_pkg;

    localparam int          DEF_ADDR_W       = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
    localparam int          DEF_RAS_DEPTH    = 4;

    // Redirect priority; a larger encoding wins.
    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_BR   = 2'd1,
        PRIO_JMP  = 2'd2,
        PRIO_EXC  = 2'd3
    } prio_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for pc_unit (only instantiated with PC_RAS_EN).
// Circular buffer: on overflow the oldest entry is overwritten and the
// occupancy count saturates at DEPTH. push+pop together replaces the top.
module pc_ras
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  top_idx, wr_idx;
    logic              wr_en;
    logic              do_pop;

    // ptr_q points at the next free slot; the top is the slot below it.
    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;

    // Next pointer/count and the slot written this cycle.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (do_pop && push) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (do_pop) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - 1'b1;
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (count_q != FULL) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Stack storage.
    // NOTE: storage has no reset; entries are only read when count_q says they were written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects (exception > jump >
// branch), misalign trapping and stall-safe redirect capture.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
    parameter int                RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              exc_req,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_valid,
    output logic              redirect_pend,
    output logic              misalign_err,
    output logic              ras_empty
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              misalign_err_q, misalign_err_d;
    prio_e             pend_prio_q, pend_prio_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    prio_e             live_prio;
    logic [ADDR_W-1:0] live_target;
    logic [ADDR_W-1:0] raw_target;
    logic              live_misalign;
    logic              live_is_jump;
    logic              take_live;
    logic [ADDR_W-1:0] jump_raw;

    assign pc_plus4 = pc_q + ADDR_W'(4);

`ifdef PC_RAS_EN
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push, ras_pop;

    // Returns take the stacked address when one exists.
    assign jump_raw = (ret && !ras_empty) ? ras_top : jump_target;
    assign ras_push = take_live && live_is_jump && call;
    assign ras_pop  = take_live && live_is_jump && ret;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras_inputs;

    assign jump_raw          = jump_target;
    assign ras_empty         = 1'b1;
    assign unused_ras_inputs = ^{call, ret};
`endif

    // Resolve the highest-priority live request; misaligned targets trap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        live_prio     = PRIO_NONE;
        live_target   = EXC_VECTOR;
        live_misalign = 1'b0;
        live_is_jump  = 1'b0;
        raw_target    = br_target;
        if (exc_req) begin
            live_prio = PRIO_EXC;
        end else if (jump_req || br_taken) begin
            live_is_jump = jump_req;
            raw_target   = jump_req ? jump_raw : br_target;
            if (is_misaligned(raw_target[1:0])) begin
                live_prio     = PRIO_EXC;
                live_misalign = 1'b1;
            end else begin
                live_prio   = jump_req ? PRIO_JMP : PRIO_BR;
                live_target = raw_target;
            end
        end
    end

    // Next-state / next-PC logic for the RUN/HOLD redirect FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_valid_d    = 1'b1;
        pend_prio_d   = pend_prio_q;
        pend_target_d = pend_target_q;
        take_live     = 1'b0;
        if (pc_valid_q) begin
            unique case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (live_prio != PRIO_NONE) begin
                            pc_d      = live_target;
                            take_live = 1'b1;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end else if (live_prio != PRIO_NONE) begin
                        pend_prio_d   = live_prio;
                        pend_target_d = live_target;
                        state_d       = ST_HOLD;
                        take_live     = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (en) begin
                        if (live_prio != PRIO_NONE && live_prio >= pend_prio_q) begin
                            pc_d      = live_target;
                            take_live = 1'b1;
                        end else begin
                            pc_d = pend_target_q;
                        end
                        pend_prio_d   = PRIO_NONE;
                        pend_target_d = '0;
                        state_d       = ST_RUN;
                    end else if (live_prio != PRIO_NONE && live_prio >= pend_prio_q) begin
                        pend_prio_d   = live_prio;
                        pend_target_d = live_target;
                        take_live     = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
        misalign_err_d = take_live && live_misalign;
    end

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_VECTOR;
            pc_valid_q     <= 1'b0;
            misalign_err_q <= 1'b0;
            pend_prio_q    <= PRIO_NONE;
            pend_target_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            state_q        <= state_d;
            pc_q           <= pc_d;
            pc_valid_q     <= pc_valid_d;
            misalign_err_q <= misalign_err_d;
            pend_prio_q    <= pend_prio_d;
            pend_target_q  <= pend_target_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_valid      = pc_valid_q;
    assign redirect_pend = (state_q == ST_HOLD);
    assign misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit; return-stack cases run when PC_RAS_EN is defined.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        exc_req;
    logic        jump_req;
    logic [31:0] jump_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        call;
    logic        ret;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        redirect_pend;
    logic        misalign_err;
    logic        ras_empty;

    int n_checks = 0;
    int n_pass   = 0;

    pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .exc_req       (exc_req),
        .jump_req      (jump_req),
        .jump_target   (jump_target),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .redirect_pend (redirect_pend),
        .misalign_err  (misalign_err),
        .ras_empty     (ras_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        exc_req     = 1'b0;
        jump_req    = 1'b0;
        br_taken    = 1'b0;
        call        = 1'b0;
        ret         = 1'b0;
        jump_target = 32'h0;
        br_target   = 32'h0;
    endtask

    task automatic do_jump(input logic [31:0] tgt, input logic c, input logic r);
        jump_req    = 1'b1;
        jump_target = tgt;
        call        = c;
        ret         = r;
    endtask

`ifdef PC_RAS_EN
    logic [31:0] call_tgts [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    logic [31:0] ret_exp   [4] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
`endif

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clear_reqs();

        // Reset state
        #12;
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'h0);
        check("rst_pend", {31'b0, redirect_pend}, 32'h0);
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);
        check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
        check("rst_plus4", pc_plus4, 32'h4);

        // Sequential run
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check("run_valid", {31'b0, pc_valid}, 32'h1);
        check("run_pc0", pc_out, 32'h0);
        step();
        check("run_pc4", pc_out, 32'h4);
        step();
        check("run_pc8", pc_out, 32'h8);
        check("run_plus4", pc_plus4, 32'hC);

        // Priority: exception beats jump beats branch
        exc_req = 1'b1;
        do_jump(32'h100, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 32'h200;
        step();
        check("prio_exc", pc_out, 32'h180);
        check("prio_no_misalign", {31'b0, misalign_err}, 32'h0);
        clear_reqs();
        step();
        check("prio_then_seq", pc_out, 32'h184);

        // Stall capture: branch, then higher-priority jump overwrites
        en = 1'b0;
        br_taken = 1'b1; br_target = 32'h200;
        step();
        check("cap_pend", {31'b0, redirect_pend}, 32'h1);
        check("cap_hold", pc_out, 32'h184);
        clear_reqs();
        do_jump(32'h300, 1'b0, 1'b0);
        step();
        check("cap_pend2", {31'b0, redirect_pend}, 32'h1);
        check("cap_hold2", pc_out, 32'h184);
        clear_reqs();
        en = 1'b1;
        step();
        check("cap_apply", pc_out, 32'h300);
        check("cap_pend_clr", {31'b0, redirect_pend}, 32'h0);

        // Lower-priority branch after captured jump is dropped
        en = 1'b0;
        do_jump(32'h500, 1'b0, 1'b0);
        step();
        clear_reqs();
        br_taken = 1'b1; br_target = 32'h600;
        step();
        check("drop_hold", pc_out, 32'h300);
        clear_reqs();
        en = 1'b1;
        step();
        check("drop_apply", pc_out, 32'h500);
        check("drop_pend_clr", {31'b0, redirect_pend}, 32'h0);

        // Live higher-priority jump at release beats a pending branch
        en = 1'b0;
        br_taken = 1'b1; br_target = 32'h700;
        step();
        clear_reqs();
        en = 1'b1;
        do_jump(32'h800, 1'b0, 1'b0);
        step();
        check("rel_live_wins", pc_out, 32'h800);
        clear_reqs();

        // Misaligned jump traps to the exception vector, one-cycle flag
        do_jump(32'h102, 1'b0, 1'b0);
        step();
        check("mis_pc", pc_out, 32'h180);
        check("mis_flag", {31'b0, misalign_err}, 32'h1);
        clear_reqs();
        step();
        check("mis_flag_drop", {31'b0, misalign_err}, 32'h0);
        check("mis_seq", pc_out, 32'h184);

        // Misaligned branch captured while stalled
        en = 1'b0;
        br_taken = 1'b1; br_target = 32'h203;
        step();
        check("mis_cap_flag", {31'b0, misalign_err}, 32'h1);
        check("mis_cap_hold", pc_out, 32'h184);
        clear_reqs();
        step();
        check("mis_cap_flag_drop", {31'b0, misalign_err}, 32'h0);
        en = 1'b1;
        step();
        check("mis_cap_apply", pc_out, 32'h180);

        // Wrap-around
        do_jump(32'hFFFF_FFFC, 1'b0, 1'b0);
        step();
        check("wrap_top", pc_out, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        clear_reqs();
        step();
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_no_flag", {31'b0, misalign_err}, 32'h0);

        // Return on empty stack uses jump_target
        do_jump(32'h600, 1'b0, 1'b1);
        step();
        check("ret_empty", pc_out, 32'h600);
        clear_reqs();

        // Reset while holding a pending redirect
        en = 1'b0;
        br_taken = 1'b1; br_target = 32'h900;
        step();
        check("hold_before_rst", {31'b0, redirect_pend}, 32'h1);
        clear_reqs();
        rst_n = 1'b0;
        #2;
        check("mid_rst_pc", pc_out, 32'h0);
        check("mid_rst_pend", {31'b0, redirect_pend}, 32'h0);
        check("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check("post_rst_pc0", pc_out, 32'h0);
        step();
        check("post_rst_pc4", pc_out, 32'h4);

`ifdef PC_RAS_EN
        // Call/return round trip
        do_jump(32'h40, 1'b0, 1'b0);
        step();
        check("ras_at40", pc_out, 32'h40);
        do_jump(32'h400, 1'b1, 1'b0);
        step();
        check("ras_call", pc_out, 32'h400);
        check("ras_nonempty", {31'b0, ras_empty}, 32'h0);
        do_jump(32'hDEAD_BEEC, 1'b0, 1'b1);
        step();
        check("ras_ret", pc_out, 32'h44);
        check("ras_empty_again", {31'b0, ras_empty}, 32'h1);

        // Overflow: five calls, four returns, oldest lost
        for (int i = 0; i < 5; i++) begin
            do_jump(call_tgts[i], 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            do_jump(32'hDEAD_BEEC, 1'b0, 1'b1);
            step();
            check($sformatf("ras_pop%0d", i), pc_out, ret_exp[i]);
        end
        check("ras_drained", {31'b0, ras_empty}, 32'h1);
        clear_reqs();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-register program counter.
- Sits at the head of the fetch stage and owns next-PC selection: sequential, branch, jump, exception.
- Adds stall-safe redirect capture, so a redirect arriving while fetch is stalled is never lost.
- Flags misaligned targets and vectors them to the exception handler.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, exception/misalign handler address.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2; used only with PC_RAS_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  fetch advance enable; 0 = stall, PC holds.
- exc_req  in  1  exception redirect request (priority 1, highest).
- jump_req  in  1  jump redirect request (priority 2).
- jump_target  in  ADDR_W  jump target.
- br_taken  in  1  taken-branch redirect request (priority 3).
- br_target  in  ADDR_W  branch target.
- call  in  1  qualifies jump_req as a call (RAS push).
- ret  in  1  qualifies jump_req as a return (RAS pop).
- pc_out  out  ADDR_W  current fetch PC.
- pc_plus4  out  ADDR_W  combinational pc_out+4, modulo 2^ADDR_W.
- pc_valid  out  1  PC valid for fetch.
- redirect_pend  out  1  a captured redirect is waiting for en.
- misalign_err  out  1  one-cycle pulse: misaligned target detected.
- ras_empty  out  1  RAS holds no entries (constant 1 without PC_RAS_EN).

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_VECTOR, pc_valid=0, redirect_pend=0, misalign_err=0, ras_empty=1.
  - FSM=RUN; pending register cleared.
- pc_valid rises on the first clk edge after rst_n deasserts; it stays 1 until the next reset.
- Live redirect:
  - Highest-priority asserted request among exc_req > jump_req > br_taken.
  - Target = EXC_VECTOR / jump_target / br_target respectively.
- Misalign check:
  - A jump or branch target with [1:0]!=0 is replaced by EXC_VECTOR at exception priority.
  - misalign_err pulses one cycle, on the edge where the redirect is accepted or captured.
- FSM state RUN:
  - en=1: pc_out <= live redirect target if any, else pc_plus4. Latency 1 cycle.
  - en=0 with a live redirect: capture target+priority into pending; go to HOLD; redirect_pend=1 next cycle; pc_out holds.
  - en=0 without a redirect: hold.
- FSM state HOLD:
  - en=0: a live redirect with priority ≥ pending priority overwrites pending (newest wins on ties); lower priority is dropped.
  - en=1: apply the live redirect if its priority ≥ pending, else apply pending. Then clear pending, go to RUN, redirect_pend=0.
- Wrap-around: PC increments modulo 2^ADDR_W; 0xFFFF_FFFC+4 gives 0x0000_0000 with no flag.
- Reset mid-HOLD: pending is discarded and the PC returns to RESET_VECTOR.
- en is don't-care before pc_valid=1.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined, call:
  - jump_req&call accepted (en=1 or captured) pushes pc_plus4 onto a RAS_DEPTH-entry circular stack.
  - On overflow, the oldest entry is overwritten; count saturates at RAS_DEPTH.
- Defined, ret:
  - jump_req&ret uses the top of stack as target (jump_target ignored) and pops.
  - If the stack is empty, jump_target is used and no pop occurs.
  - A popped target is misalign-checked like any other.
  - ras_empty reflects count==0.
- Defined, call&ret together: treated as ret then push (net swap of top).
- Stack pointer and count change only when the redirect is applied or captured; a dropped redirect does not touch the stack.
- Not defined: call/ret are ignored, ras_empty is tied to 1, and no stack storage is synthesised.

Decomposition:
- Shared package mips_pkg:
  - ADDR_W default.
  - RESET_VECTOR and EXC_VECTOR constants.
  - Redirect priority enum: NONE=0, BR=1, JMP=2, EXC=3.
  - FSM state typedef: RUN, HOLD.
- One natural sub-module: pc_ras, holding the circular stack, pointer and count, instantiated under PC_RAS_EN.

Test Plan:
- Reset/run:
  - Release rst_n, en=1, no requests.
  - pc_out goes 0x0 → 0x4 → 0x8; pc_valid=1 from the first edge.
- Priority:
  - en=1, exc_req=1, jump_req=1 (0x100), br_taken=1 (0x200) in the same cycle.
  - Next pc_out=0x180.
- Stall capture:
  - en=0, br_taken=1 (0x200) one cycle, then jump_req (0x300) while still stalled.
  - redirect_pend=1; pc_out holds. After en=1: pc_out=0x300, redirect_pend=0.
  - Separately: a lower-priority br after a captured jump is dropped.
- Misalign:
  - jump_req to 0x102.
  - pc_out=0x180 next cycle; misalign_err high exactly one cycle.
- Wrap:
  - Force pc_out=0xFFFF_FFFC via jump, then en=1.
  - pc_out=0x0000_0000.
- RAS (PC_RAS_EN):
  - Call from 0x40 to 0x400, then ret with jump_target=0xDEAD_BEEC → pc_out=0x44, ras_empty=1.
  - Push 5 calls with RAS_DEPTH=4, then pop 4: the returns come back newest-first and the oldest return address is lost.
